udm_uart_rx: RTL and testbench

//  Serial receive front-end of the UART debug module (UDM) in the kerygma SoC.

---
 rtl/udm_uart_pkg.sv | 16 +
 rtl/udm_sync.sv | 21 ++
 rtl/udm_uart_rx.sv | 134 +++++++++++++
 tb/tb_udm_uart_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/udm_uart_pkg.sv
// Shared UART definitions for the UDM receive path and the future transmit path.
package udm_uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int MIN_DIV   = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

endpackage

// File: rtl/udm_sync.sv
// Flop-chain synchronizer for an asynchronous single-bit input; reset value is configurable.
module udm_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) chain_q <= {STAGES{RST_VAL}};
    else       chain_q <= {chain_q[STAGES-2:0], d_i};
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/udm_uart_rx.sv
// UDM UART receiver: synchronizes rx, deframes 8-bit characters (optional parity) and
// presents each byte through a one-entry valid/ready buffer.
//   state  | meaning
//   IDLE   | line idle, waiting for a falling edge on rx_s
//   START  | timing to mid start bit; high there means glitch, drop back to IDLE
//   DATA   | sampling 8 data bits, LSB first
//   PARITY | sampling parity bit and latching mismatch
//   STOP   | sampling stop bit; push byte or flag an error
//   BREAK  | stop bit was low; wait for the line to return high
module udm_uart_rx
  import udm_uart_pkg::*;
#(
  parameter int DIV_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] divider_i,
  input  logic             parity_en_i,
  input  logic             parity_odd_i,
  output logic [7:0]       data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             frame_err_o,
  output logic             parity_err_o,
  output logic             overrun_o,
  output logic             busy_o
);

  logic                 rx_s;
  uart_state_e          state_q, state_d;
  logic [DIV_W-1:0]     div_q, cnt_q, div_eff;
  logic [2:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q;
  logic                 tick;
  logic                 push, frame_err_set, parity_err_set;

  udm_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  assign div_eff = (divider_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : divider_i;
  assign tick    = (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (tick) state_d = rx_s ? IDLE : DATA;
      DATA:    if (tick && bit_q == 3'(DATA_BITS-1)) state_d = parity_en_i ? PARITY : STOP;
      PARITY:  if (tick) state_d = STOP;
      STOP:    if (tick) state_d = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame error wins over parity error, so at most one flag fires per frame.
  always_comb begin
    push           = 1'b0;
    frame_err_set  = 1'b0;
    parity_err_set = 1'b0;
    if (state_q == STOP && tick) begin
      if (!rx_s)          frame_err_set  = 1'b1;
      else if (par_err_q) parity_err_set = 1'b1;
      else                push           = 1'b1;
    end
  end

  assign busy_o = (state_q != IDLE);

  // First sample lands half a bit after the start edge, then every full bit period.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q     <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            div_q     <= div_eff;
            cnt_q     <= (div_eff >> 1) - DIV_W'(1);
            bit_q     <= '0;
            par_err_q <= 1'b0;
          end
        end
        START, DATA, PARITY, STOP: begin
          cnt_q <= tick ? div_q - DIV_W'(1) : cnt_q - DIV_W'(1);
          if (tick && state_q == DATA) begin
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            bit_q   <= bit_q + 3'd1;
          end
          if (tick && state_q == PARITY)
            par_err_q <= (rx_s != (^shift_q ^ parity_odd_i));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      frame_err_o  <= frame_err_set;
      parity_err_o <= parity_err_set;
      overrun_o    <= push && valid_o && !ready_i;
      if (push && (!valid_o || ready_i)) begin
        data_o  <= shift_q;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_udm_uart_rx.sv
// Self-checking bench for udm_uart_rx: directed scenarios plus randomized frames checked
// against a frame-level outcome model.
`timescale 1ns/1ps
module tb_udm_uart_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [31:0] divider;
  logic        par_en, par_odd, ready;
  logic [7:0]  data;
  logic        valid, ferr, perr, ovr, busy;

  udm_uart_rx #(.DIV_W(32), .SYNC_STAGES(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_i         (rx),
    .divider_i    (divider),
    .parity_en_i  (par_en),
    .parity_odd_i (par_odd),
    .data_o       (data),
    .valid_o      (valid),
    .ready_i      (ready),
    .frame_err_o  (ferr),
    .parity_err_o (perr),
    .overrun_o    (ovr),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Event monitor, sampled on the falling edge.
  int         n_acc = 0, n_ferr = 0, n_perr = 0, n_ovr = 0, n_valid_hi = 0;
  logic [7:0] last_acc = 8'h00;
  int         last_acc_cyc = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) n_valid_hi++;
      if (valid && ready) begin
        n_acc++;
        last_acc     = data;
        last_acc_cyc = cyc;
      end
      if (ferr) n_ferr++;
      if (perr) n_perr++;
      if (ovr)  n_ovr++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outcome of one frame: 0 byte delivered, 1 framing error, 2 parity error.
  function automatic int frame_outcome(input logic [7:0] d, input logic pen, input logic odd,
                                       input logic pbit, input logic stop);
    int ones;
    if (!stop) return 1;
    ones = $countones(d) + int'(pbit);
    if (pen && ((ones % 2) != int'(odd))) return 2;
    return 0;
  endfunction

  function automatic logic good_parity(input logic [7:0] d, input logic odd);
    return (($countones(d) % 2) == 1) ? !odd : odd;
  endfunction

  int k_start;

  task automatic drive_bit(input logic b, input int nbits);
    rx = b;
    repeat (nbits) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int div, input logic pen,
                            input logic pbit, input logic stop, input int hold);
    int de;
    de = (div < 2) ? 2 : div;
    @(posedge clk); #1;
    divider = 32'(div);
    par_en  = pen;
    k_start = cyc;
    drive_bit(1'b0, de);
    for (int i = 0; i < 8; i++) drive_bit(d[i], de);
    if (pen) drive_bit(pbit, de);
    drive_bit(stop, de);
    if (!stop) drive_bit(1'b0, hold);
    rx = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    check_eq({tag, "_idle"}, 32'(t < 400), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input int div, input logic pen,
                           input logic odd, input logic pbit, input logic stop, input int hold);
    int a0, f0, p0, o0, kind;
    a0 = n_acc; f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
    par_odd = odd;
    kind = frame_outcome(d, pen, odd, pbit, stop);
    send_frame(d, div, pen, pbit, stop, hold);
    wait_idle(tag);
    check_eq({tag, "_bytes"}, 32'(n_acc - a0), 32'(kind == 0));
    if (kind == 0) check_eq({tag, "_data"}, 32'(last_acc), 32'(d));
    check_eq({tag, "_ferr"}, 32'(n_ferr - f0), 32'(kind == 1));
    check_eq({tag, "_perr"}, 32'(n_perr - p0), 32'(kind == 2));
    check_eq({tag, "_ovr"}, 32'(n_ovr - o0), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, f0, p0, o0, v0, lat, de, h;
    rst = 1'b1; rx = 1'b1; divider = 32'd868; par_en = 1'b0; par_odd = 1'b0; ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_data",  32'(data),  32'd0);
    check_eq("rst_busy",  32'(busy),  32'd0);
    check_eq("rst_flags", {29'd0, ferr, perr, ovr}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Baseline 8N1 byte at 868 cycles per bit, with latency and pulse width.
    v0 = n_valid_hi;
    run_frame("t1", 8'h55, 868, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    lat = last_acc_cyc - k_start;
    check_eq("t1_latency", 32'(lat >= 8247 && lat <= 8251), 32'd1);
    check_eq("t1_valid_width", 32'(n_valid_hi - v0), 32'd1);

    // Short low glitch: rejected at the mid-start sample.
    a0 = n_acc; f0 = n_ferr; p0 = n_perr;
    @(posedge clk); #1 rx = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check_eq("t2_busy_mid", 32'(busy), 32'd1);
    repeat (100) @(posedge clk);
    #1 rx = 1'b1;
    repeat (250) @(posedge clk);
    @(negedge clk); #1;
    check_eq("t2_busy_end", 32'(busy), 32'd0);
    check_eq("t2_events", 32'((n_acc - a0) + (n_ferr - f0) + (n_perr - p0)), 32'd0);

    // Framing error with a long break, then a clean byte.
    run_frame("t3a", 8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b0, 2000);
    run_frame("t3b", 8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1, 0);

    // Even parity: wrong parity bit, then the correct one.
    run_frame("t4a", 8'h07, 16, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    run_frame("t4b", 8'h07, 16, 1'b1, 1'b0, 1'b1, 1'b1, 0);

    // Overrun: consumer stalled across two frames.
    ready = 1'b0;
    a0 = n_acc; o0 = n_ovr;
    send_frame(8'h11, 16, 1'b0, 1'b0, 1'b1, 0);
    send_frame(8'h22, 16, 1'b0, 1'b0, 1'b1, 0);
    wait_idle("t5");
    check_eq("t5_valid_held", 32'(valid), 32'd1);
    check_eq("t5_data_held",  32'(data),  32'h11);
    check_eq("t5_overrun",    32'(n_ovr - o0), 32'd1);
    @(posedge clk); #1 ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk); #1;
    check_eq("t5_pop_count", 32'(n_acc - a0), 32'd1);
    check_eq("t5_pop_data",  32'(last_acc), 32'h11);
    check_eq("t5_valid_drop", 32'(valid), 32'd0);

    // Push and pop in the same cycle: new byte replaces, no overrun.
    send_frame(8'h33, 16, 1'b0, 1'b0, 1'b1, 0);
    wait_idle("t5r0");
    a0 = n_acc; o0 = n_ovr;
    de = 16; h = de / 2;
    fork
      send_frame(8'h44, de, 1'b0, 1'b0, 1'b1, 0);
      begin
        @(posedge clk); #1;
        repeat (2 + h + 9 * de) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    wait_idle("t5r");
    check_eq("t5r_pop_data", 32'(last_acc), 32'h33);
    check_eq("t5r_pop_count", 32'(n_acc - a0), 32'd1);
    check_eq("t5r_valid", 32'(valid), 32'd1);
    check_eq("t5r_data", 32'(data), 32'h44);
    check_eq("t5r_overrun", 32'(n_ovr - o0), 32'd0);
    ready = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a frame.
    a0 = n_acc;
    @(posedge clk); #1;
    divider = 32'd16;
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 32);
    check_eq("t6_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_valid", 32'(valid), 32'd0);
    check_eq("t6_data", 32'(data), 32'd0);
    drive_bit(1'b1, 16 * 8);
    check_eq("t6_no_byte", 32'(n_acc - a0), 32'd0);
    run_frame("t6b", 8'h80, 16, 1'b0, 1'b0, 1'b0, 1'b1, 0);

    // Randomized frames, including dividers below the minimum.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic       pen, odd, pbit, stop;
      int         div, hold;
      d    = 8'($urandom);
      div  = int'($urandom_range(0, 20));
      pen  = 1'($urandom);
      odd  = 1'($urandom);
      pbit = good_parity(d, odd) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 5) != 0);
      hold = int'($urandom_range(1, 30));
      run_frame($sformatf("rnd%0d", n), d, div, pen, odd, pbit, stop, hold);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
